uart_receiver: RTL and testbench

UART_RECEIVER -- requirements
Module: uart_receiver

---
 rtl/uart_pkg.sv | 20 ++
 rtl/uart_rx_sync.sv | 23 ++
 rtl/uart_receiver.sv | 157 +++++++++++++++
 tb/tb_uart_receiver.sv | 238 +++++++++++++++++++++++
 4 files changed

// File: rtl/uart_pkg.sv
// rtl/uart_pkg.sv - shared line levels, default oversampling and FSM states for the UART receiver
package uart_pkg;

  localparam int   DEFAULT_OVERSAMPLE = 16;
  localparam logic IDLE_LEVEL  = 1'b1;
  localparam logic START_LEVEL = 1'b0;
  localparam logic STOP_LEVEL  = 1'b1;

  typedef enum logic [2:0] {
    ST_IDLE      = 3'd0,
    ST_START     = 3'd1,
    ST_DATA      = 3'd2,
`ifdef UART_RX_PARITY_EN
    ST_PARITY    = 3'd3,
`endif
    ST_STOP      = 3'd4,
    ST_WAIT_HIGH = 3'd5
  } rx_state_e;

endpackage

// File: rtl/uart_rx_sync.sv
// rtl/uart_rx_sync.sv - two-flop synchronizer for the serial line, resets to the idle level
module uart_rx_sync
  import uart_pkg::*;
(
  input  logic clk,
  input  logic rstn,
  input  logic async_in,
  output logic sync_out
);

  logic meta;

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      meta     <= IDLE_LEVEL;
      sync_out <= IDLE_LEVEL;
    end else begin
      meta     <= async_in;
      sync_out <= meta;
    end
  end

endmodule

// File: rtl/uart_receiver.sv
// rtl/uart_receiver.sv - oversampling UART receiver with single-entry holding register
// Optional even-parity bit and parity_err output enabled by UART_RX_PARITY_EN.
module uart_receiver
  import uart_pkg::*;
#(
  parameter int OVERSAMPLE = DEFAULT_OVERSAMPLE,
  parameter int DATA_BITS  = 8
) (
  input  logic                 clk,
  input  logic                 rstn,
  input  logic                 serial_in,
  input  logic                 sample_tick,
  output logic [DATA_BITS-1:0] rx_data,
  output logic                 rx_valid,
  input  logic                 rx_ack,
  output logic                 frame_err,
`ifdef UART_RX_PARITY_EN
  output logic                 parity_err,
`endif
  output logic                 overrun,
  output logic                 busy
);

  localparam int TICK_W = $clog2(OVERSAMPLE);
  localparam int BIT_W  = $clog2(DATA_BITS + 1);

  rx_state_e             state, state_nxt;
  logic                  line_s, line_d;
  logic [TICK_W-1:0]     tick_cnt;
  logic [BIT_W-1:0]      bit_cnt;
  logic [DATA_BITS-1:0]  shift_reg;
  logic                  mid_tick, bit_tick;
  logic                  data_sample, stop_sample;
  logic                  done, done_ferr;
`ifdef UART_RX_PARITY_EN
  logic                  parity_sample, done_perr;
`endif

  uart_rx_sync u_sync (
    .clk      (clk),
    .rstn     (rstn),
    .async_in (serial_in),
    .sync_out (line_s)
  );

  assign mid_tick = sample_tick && (tick_cnt == TICK_W'(OVERSAMPLE / 2 - 1));
  assign bit_tick = sample_tick && (tick_cnt == TICK_W'(OVERSAMPLE - 1));

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) state <= ST_IDLE;
    else       state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      ST_IDLE:
        if (line_d == IDLE_LEVEL && line_s == START_LEVEL) state_nxt = ST_START;
      ST_START:
        if (mid_tick) state_nxt = (line_s == START_LEVEL) ? ST_DATA : ST_IDLE;
      ST_DATA:
        if (bit_tick && bit_cnt == BIT_W'(DATA_BITS - 1)) begin
`ifdef UART_RX_PARITY_EN
          state_nxt = ST_PARITY;
`else
          state_nxt = ST_STOP;
`endif
        end
`ifdef UART_RX_PARITY_EN
      ST_PARITY:
        if (bit_tick) state_nxt = ST_STOP;
`endif
      ST_STOP:
        if (bit_tick) state_nxt = (line_s == STOP_LEVEL) ? ST_IDLE : ST_WAIT_HIGH;
      ST_WAIT_HIGH:
        if (line_s == IDLE_LEVEL) state_nxt = ST_IDLE;
      default:
        state_nxt = ST_IDLE;
    endcase
  end

  always_comb begin
    busy        = (state != ST_IDLE);
    data_sample = (state == ST_DATA) && bit_tick;
    stop_sample = (state == ST_STOP) && bit_tick;
`ifdef UART_RX_PARITY_EN
    parity_sample = (state == ST_PARITY) && bit_tick;
`endif
  end

  // Bit-timing datapath; the tick counter restarts on every state change.
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      line_d    <= IDLE_LEVEL;
      tick_cnt  <= '0;
      bit_cnt   <= '0;
      shift_reg <= '0;
      done      <= 1'b0;
      done_ferr <= 1'b0;
`ifdef UART_RX_PARITY_EN
      done_perr <= 1'b0;
`endif
    end else begin
      line_d <= line_s;
      done   <= stop_sample;
      if (state != state_nxt || bit_tick)
        tick_cnt <= '0;
      else if (sample_tick && state != ST_IDLE && state != ST_WAIT_HIGH)
        tick_cnt <= tick_cnt + 1'b1;
      if (state == ST_START)
        bit_cnt <= '0;
      else if (data_sample)
        bit_cnt <= bit_cnt + 1'b1;
      if (data_sample)
        shift_reg <= {line_s, shift_reg[DATA_BITS-1:1]};
`ifdef UART_RX_PARITY_EN
      if (parity_sample)
        done_perr <= (^shift_reg) ^ line_s;
`endif
      if (stop_sample)
        done_ferr <= (line_s != STOP_LEVEL);
    end
  end

  // A completing frame is dropped only if the previous one is still unacknowledged.
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      rx_data   <= '0;
      rx_valid  <= 1'b0;
      frame_err <= 1'b0;
      overrun   <= 1'b0;
`ifdef UART_RX_PARITY_EN
      parity_err <= 1'b0;
`endif
    end else if (done) begin
      if (rx_valid && !rx_ack) begin
        overrun <= 1'b1;
      end else begin
        rx_data   <= shift_reg;
        rx_valid  <= 1'b1;
        frame_err <= done_ferr;
        overrun   <= 1'b0;
`ifdef UART_RX_PARITY_EN
        parity_err <= done_perr;
`endif
      end
    end else if (rx_valid && rx_ack) begin
      rx_valid  <= 1'b0;
      frame_err <= 1'b0;
      overrun   <= 1'b0;
`ifdef UART_RX_PARITY_EN
      parity_err <= 1'b0;
`endif
    end
  end

endmodule

// File: tb/tb_uart_receiver.sv
// tb/tb_uart_receiver.sv - self-checking bench: vector table, corner sequences, random frames vs model
module tb_uart_receiver;

  logic       clk = 1'b0;
  logic       rstn, serial_in, sample_tick, rx_ack;
  logic [7:0] rx_data;
  logic       rx_valid, frame_err, overrun, busy;
`ifdef UART_RX_PARITY_EN
  logic       parity_err;
`endif

  int n_cmp = 0;
  int n_bad = 0;

  uart_receiver #(.OVERSAMPLE(16), .DATA_BITS(8)) dut (
    .clk         (clk),
    .rstn        (rstn),
    .serial_in   (serial_in),
    .sample_tick (sample_tick),
    .rx_data     (rx_data),
    .rx_valid    (rx_valid),
    .rx_ack      (rx_ack),
    .frame_err   (frame_err),
`ifdef UART_RX_PARITY_EN
    .parity_err  (parity_err),
`endif
    .overrun     (overrun),
    .busy        (busy)
  );

  always #5 clk = ~clk;

  initial begin
    sample_tick = 1'b0;
    forever begin
      repeat (3) @(negedge clk);
      sample_tick = 1'b1;
      @(negedge clk);
      sample_tick = 1'b0;
    end
  end

  initial begin
    #700000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h required %0h", name, act, exp);
    end
  endtask

  task automatic check_all(input string name, input logic [7:0] d, input logic v,
                           input logic fe, input logic ov);
    check({name, ".rx_data"}, 32'(rx_data), 32'(d));
    check({name, ".rx_valid"}, 32'(rx_valid), 32'(v));
    check({name, ".frame_err"}, 32'(frame_err), 32'(fe));
    check({name, ".overrun"}, 32'(overrun), 32'(ov));
`ifdef UART_RX_PARITY_EN
    check({name, ".parity_err"}, 32'(parity_err), 32'd0);
`endif
  endtask

  task automatic wait_ticks(input int n);
    for (int i = 0; i < n; i++) begin
      do @(posedge clk); while (sample_tick !== 1'b1);
    end
    #1;
  endtask

  task automatic send_bit(input logic b);
    serial_in = b;
    wait_ticks(16);
  endtask

  task automatic send_frame(input logic [7:0] d, input logic stop);
    send_bit(1'b0);
    for (int i = 0; i < 8; i++) send_bit(d[i]);
`ifdef UART_RX_PARITY_EN
    send_bit(^d);
`endif
    send_bit(stop);
    if (!stop) send_bit(1'b1);
  endtask

  task automatic do_ack();
    @(negedge clk);
    rx_ack = 1'b1;
    @(negedge clk);
    rx_ack = 1'b0;
  endtask

  // Reference model: the holding register as the consumer sees it.
  logic [7:0] m_data;
  logic       m_valid, m_fe, m_ov;

  function automatic void model_frame(input logic [7:0] d, input logic stop);
    if (m_valid) m_ov = 1'b1;
    else begin
      m_data = d; m_valid = 1'b1; m_fe = !stop;
    end
  endfunction

  function automatic void model_ack();
    if (m_valid) begin
      m_valid = 1'b0; m_fe = 1'b0; m_ov = 1'b0;
    end
  endfunction

  typedef struct {
    bit         send;
    logic [7:0] data;
    bit         stop;
    logic [7:0] e_data;
    bit         e_valid;
    bit         e_fe;
    bit         e_ov;
  } vec_t;

  vec_t vecs[8];

  initial begin
    logic [7:0] rd;
    logic       rs;
    bit         seen, found;

    vecs[0] = '{1'b1, 8'hA5, 1'b1, 8'hA5, 1'b1, 1'b0, 1'b0};
    vecs[1] = '{1'b0, 8'h00, 1'b0, 8'hA5, 1'b0, 1'b0, 1'b0};
    vecs[2] = '{1'b0, 8'h00, 1'b0, 8'hA5, 1'b0, 1'b0, 1'b0};
    vecs[3] = '{1'b1, 8'h3C, 1'b1, 8'h3C, 1'b1, 1'b0, 1'b0};
    vecs[4] = '{1'b1, 8'h81, 1'b1, 8'h3C, 1'b1, 1'b0, 1'b1};
    vecs[5] = '{1'b0, 8'h00, 1'b0, 8'h3C, 1'b0, 1'b0, 1'b0};
    vecs[6] = '{1'b1, 8'h00, 1'b0, 8'h00, 1'b1, 1'b1, 1'b0};
    vecs[7] = '{1'b0, 8'h00, 1'b0, 8'h00, 1'b0, 1'b0, 1'b0};

    rstn = 1'b0; serial_in = 1'b1; rx_ack = 1'b0;
    repeat (3) @(negedge clk);
    check_all("reset", 8'h00, 1'b0, 1'b0, 1'b0);
    check("reset.busy", 32'(busy), 32'd0);
    rstn = 1'b1;
    wait_ticks(4);

    for (int i = 0; i < 8; i++) begin
      if (vecs[i].send) send_frame(vecs[i].data, vecs[i].stop);
      else do_ack();
      check_all($sformatf("vec%0d", i), vecs[i].e_data, vecs[i].e_valid, vecs[i].e_fe, vecs[i].e_ov);
      if (i == 0) check("vec0.busy", 32'(busy), 32'd0);
    end

    // Short low glitch: must be rejected as a false start.
    serial_in = 1'b0;
    wait_ticks(5);
    check("false_start.busy_mid", 32'(busy), 32'd1);
    serial_in = 1'b1;
    wait_ticks(20);
    check("false_start.busy", 32'(busy), 32'd0);
    check("false_start.rx_valid", 32'(rx_valid), 32'd0);

    // Break: line low through the stop bit and three more bit times.
    serial_in = 1'b0;
    wait_ticks(16 * 13);
    check_all("break", 8'h00, 1'b1, 1'b1, 1'b0);
    check("break.busy_held", 32'(busy), 32'd1);
    serial_in = 1'b1;
    wait_ticks(2);
    check("break.busy_release", 32'(busy), 32'd0);
    do_ack();
    check_all("break_ack", 8'h00, 1'b0, 1'b0, 1'b0);

    // Acknowledge landing on the completion edge of the next frame.
    send_frame(8'h12, 1'b1);
    check_all("pend12", 8'h12, 1'b1, 1'b0, 1'b0);
    seen = 0; found = 0;
    fork
      send_frame(8'h55, 1'b1);
      begin
        for (int i = 0; i < 5000; i++) begin
          @(negedge clk);
          if (busy) seen = 1;
          else if (seen) begin found = 1; break; end
        end
        if (found) begin
          rx_ack = 1'b1;
          @(negedge clk);
          rx_ack = 1'b0;
        end
      end
    join
    check("coincident.edge_found", 32'(found), 32'd1);
    check_all("coincident", 8'h55, 1'b1, 1'b0, 1'b0);

    // Reset in the middle of data bit 4 of 0xFF.
    serial_in = 1'b0;
    wait_ticks(16);
    serial_in = 1'b1;
    wait_ticks(16 * 4 + 8);
    @(negedge clk);
    rstn = 1'b0;
    repeat (2) @(negedge clk);
    check_all("midreset", 8'h00, 1'b0, 1'b0, 1'b0);
    check("midreset.busy", 32'(busy), 32'd0);
    @(negedge clk);
    rstn = 1'b1;
    wait_ticks(16 * 6);
    check("midreset.after_busy", 32'(busy), 32'd0);
    check("midreset.after_valid", 32'(rx_valid), 32'd0);
    send_frame(8'h0F, 1'b1);
    check_all("after_reset", 8'h0F, 1'b1, 1'b0, 1'b0);
    do_ack();

    m_data = 8'h0F; m_valid = 1'b0; m_fe = 1'b0; m_ov = 1'b0;
    for (int i = 0; i < 20; i++) begin
      rd = 8'($urandom);
      rs = ($urandom_range(0, 4) != 0);
      send_frame(rd, rs);
      model_frame(rd, rs);
      check_all($sformatf("rnd%0d", i), m_data, m_valid, m_fe, m_ov);
      if ($urandom_range(0, 1) == 1) begin
        do_ack();
        model_ack();
        check_all($sformatf("rnd%0d_ack", i), m_data, m_valid, m_fe, m_ov);
        if ($urandom_range(0, 3) == 0) begin
          do_ack();
          model_ack();
          check_all($sformatf("rnd%0d_ack2", i), m_data, m_valid, m_fe, m_ov);
        end
      end
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
